uart_receiver: RTL and testbench

- UART receive path: the downstream counterpart of the team's transmitter.
- Recovers 8N1 frames from the asynchronous serial input `rx`: 1 start bit '0', 8 data bits LSB first, 1 stop bit '1', idle high.
- Presents each received byte as parallel data with a one-cycle valid strobe.
- Sits between the board RX pin and byte-consuming logic (command decoder, display, loopback to the transmitter).

---
 rtl/uart_receiver_pkg.sv | 21 ++
 rtl/uart_rx_sync.sv | 50 +++++
 rtl/uart_receiver.sv | 160 ++++++++++++++++
 tb/tb_uart_receiver.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_receiver_pkg.sv
// Shared UART definitions (uart_defs) used by the receiver and the transmitter side.
// Frame-state encodings, data width, default bit period and the cycle-counter width.
package uart_receiver_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

    localparam int DATA_BITS        = 8;
    localparam int DEFAULT_BPS_PARA = 1250;
    localparam int CNT_W            = 13;

    // Two-of-three vote used to filter single-cycle line glitches at a sample point.
    function automatic logic majority3(input logic [2:0] v);
        return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer and falling-edge detector for the UART RX line.
// With UART_RX_MAJORITY_EN defined, also keeps a 3-sample history and provides its majority vote.
module uart_rx_sync
    import uart_receiver_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic rx,
    output logic rx_s2,
`ifdef UART_RX_MAJORITY_EN
    output logic rx_maj,
`endif
    output logic start_edge
);

    logic rx_s1;
    logic rx_s2_q;
    logic rx_s3;

    // Flops reset to the idle line level so reset itself never looks like a start edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_s1   <= 1'b1;
            rx_s2_q <= 1'b1;
            rx_s3   <= 1'b1;
        end else begin
            rx_s1   <= rx;
            rx_s2_q <= rx_s1;
            rx_s3   <= rx_s2_q;
        end
    end

    assign rx_s2      = rx_s2_q;
    assign start_edge = rx_s3 & ~rx_s2_q;

`ifdef UART_RX_MAJORITY_EN
    logic rx_s4;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_s4 <= 1'b1;
        end else begin
            rx_s4 <= rx_s3;
        end
    end

    assign rx_maj = majority3({rx_s4, rx_s3, rx_s2_q});
`endif

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver: recovers bytes from rx with a one-cycle rx_valid / frame_err strobe.
// Optional UART_RX_MAJORITY_EN selects 2-of-3 majority sampling instead of single-point sampling.
module uart_receiver
    import uart_receiver_pkg::*;
#(
    parameter int BPS_PARA = DEFAULT_BPS_PARA
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       rx_busy
);

    localparam logic [CNT_W-1:0] HALF     = CNT_W'(BPS_PARA >> 1);
    localparam logic [CNT_W-1:0] LAST     = CNT_W'(BPS_PARA - 1);
    localparam logic [2:0]       LAST_BIT = 3'(DATA_BITS - 1);

    if (BPS_PARA < 8 || BPS_PARA > 8191) begin : g_bad_bps
        $error("uart_receiver: BPS_PARA out of range 8..8191");
    end

    uart_state_e      state;
    uart_state_e      next_state;
    logic [CNT_W-1:0] cycle_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift_reg;
    logic             rx_s2;
    logic             start_edge;
    logic             sample_bit;
    logic             sample_tick;
    logic             shift_en;
    logic             load_data;
    logic             set_err;

`ifdef UART_RX_MAJORITY_EN
    logic rx_maj;

    uart_rx_sync u_sync (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx         (rx),
        .rx_s2      (rx_s2),
        .rx_maj     (rx_maj),
        .start_edge (start_edge)
    );

    assign sample_bit = rx_maj;
`else
    uart_rx_sync u_sync (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx         (rx),
        .rx_s2      (rx_s2),
        .start_edge (start_edge)
    );

    assign sample_bit = rx_s2;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // A start bit that reads high at mid-bit is a glitch and is dropped silently.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (start_edge) begin
                    next_state = START;
                end
            end
            START: begin
                if (cycle_cnt == HALF) begin
                    next_state = sample_bit ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cycle_cnt == LAST && bit_idx == LAST_BIT) begin
                    next_state = STOP;
                end
            end
            STOP: begin
                if (cycle_cnt == LAST) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        sample_tick = 1'b0;
        shift_en    = 1'b0;
        load_data   = 1'b0;
        set_err     = 1'b0;
        case (state)
            START: sample_tick = (cycle_cnt == HALF);
            DATA: begin
                sample_tick = (cycle_cnt == LAST);
                shift_en    = (cycle_cnt == LAST);
            end
            STOP: begin
                sample_tick = (cycle_cnt == LAST);
                load_data   = (cycle_cnt == LAST) &&  sample_bit;
                set_err     = (cycle_cnt == LAST) && !sample_bit;
            end
            default: ;
        endcase
    end

    // Counter restarts on every state entry and every sample so each bit period is measured afresh.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_cnt <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
        end else begin
            if (state == IDLE || sample_tick || next_state != state) begin
                cycle_cnt <= '0;
            end else begin
                cycle_cnt <= cycle_cnt + 1'b1;
            end

            if (state != DATA) begin
                bit_idx <= '0;
            end else if (shift_en) begin
                bit_idx <= bit_idx + 1'b1;
            end

            if (shift_en) begin
                shift_reg[bit_idx] <= sample_bit;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_data   <= 8'h00;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rx_valid  <= load_data;
            frame_err <= set_err;
            if (load_data) begin
                rx_data <= shift_reg;
            end
        end
    end

    assign rx_busy = (state != IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver: table of frames plus hand-written corner sequences.
module tb_uart_receiver;

    localparam int BPS  = 20;
    localparam int HALF = BPS >> 1;
    localparam int LAT  = 4 + HALF + 9 * BPS;

    typedef struct {
        string      name;
        logic [7:0] data;
        logic       stop;
        int         exp_valid;
        int         exp_err;
        logic [7:0] exp_data;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       rx_busy;

    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;
    int         valid_cnt = 0;
    int         err_cnt = 0;
    int         err_cyc = 0;
    bit         busy_seen = 1'b0;
    int         valid_cyc[$];
    logic [7:0] valid_data[$];

    uart_receiver #(.BPS_PARA(BPS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx        (rx),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .frame_err (frame_err),
        .rx_busy   (rx_busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rx_valid) begin
            valid_cnt++;
            valid_cyc.push_back(cyc);
            valid_data.push_back(rx_data);
        end
        if (frame_err) begin
            err_cnt++;
            err_cyc = cyc;
        end
        if (rx_valid && frame_err) begin
            checks++;
            errors++;
            $display("[TB] FAIL valid_and_err_together actual=1 required=0 at cycle %0d", cyc);
        end
        if (rx_busy) busy_seen = 1'b1;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Drives one full frame cycle by cycle; glitch raises rx for one clock at each data sample point.
    task automatic applyStimulus(input logic [7:0] d, input logic stop, input bit glitch, output int k);
        logic [9:0] bits;
        bits = {stop, d, 1'b0};
        k = 0;
        for (int b = 0; b < 10; b++) begin
            for (int c = 0; c < BPS; c++) begin
                @(posedge clk);
                #1;
                if (b == 0 && c == 0) k = cyc;
                rx = (glitch && b >= 1 && b <= 8 && c == HALF + 1) ? 1'b1 : bits[b];
            end
        end
    endtask

    task automatic checkFrame(input vec_t v, input int k, input int v0, input int e0);
        checkOutput({v.name, "_valid_count"}, valid_cnt - v0, v.exp_valid);
        checkOutput({v.name, "_err_count"}, err_cnt - e0, v.exp_err);
        if (v.exp_valid == 1 && valid_cyc.size() > 0) begin
            checkOutput({v.name, "_valid_latency"}, valid_cyc[$] - k, LAT);
            checkOutput({v.name, "_data_at_pulse"}, valid_data[$], v.exp_data);
        end
        if (v.exp_err == 1) checkOutput({v.name, "_err_latency"}, err_cyc - k, LAT);
        checkOutput({v.name, "_rx_data"}, rx_data, v.exp_data);
        checkOutput({v.name, "_busy_seen"}, busy_seen, 1);
    endtask

    vec_t vecs[6];

    initial begin
        int         k, k2, v0, e0, n;
        logic [7:0] maj_exp;

        vecs[0] = '{"f55", 8'h55, 1'b1, 1, 0, 8'h55};
        vecs[1] = '{"f11", 8'h11, 1'b1, 1, 0, 8'h11};
        vecs[2] = '{"fC4_bad_stop", 8'hC4, 1'b0, 0, 1, 8'h11};
        vecs[3] = '{"f3C", 8'h3C, 1'b1, 1, 0, 8'h3C};
        vecs[4] = '{"f00", 8'h00, 1'b1, 1, 0, 8'h00};
        vecs[5] = '{"fFF", 8'hFF, 1'b1, 1, 0, 8'hFF};

        repeat (3) @(negedge clk);
        checkOutput("reset_rx_data", rx_data, 8'h00);
        checkOutput("reset_rx_valid", rx_valid, 0);
        checkOutput("reset_frame_err", frame_err, 0);
        checkOutput("reset_rx_busy", rx_busy, 0);
        rst_n = 1'b1;
        repeat (5) @(posedge clk);

        for (int i = 0; i < 6; i++) begin
            v0 = valid_cnt;
            e0 = err_cnt;
            busy_seen = 1'b0;
            applyStimulus(vecs[i].data, vecs[i].stop, 1'b0, k);
            repeat (2) @(negedge clk);
            checkFrame(vecs[i], k, v0, e0);
            if (!vecs[i].stop) begin
                // Line stays low (break): must not retrigger until it goes high again.
                repeat (3 * BPS) @(negedge clk);
                checkOutput("break_no_retrigger_busy", rx_busy, 0);
                checkOutput("break_no_new_pulses", (valid_cnt - v0) + (err_cnt - e0), 1);
                rx = 1'b1;
            end
            repeat (BPS) @(posedge clk);
        end

        $display("[TB] back-to-back frames A3, 0F");
        v0 = valid_cnt;
        applyStimulus(8'hA3, 1'b1, 1'b0, k);
        applyStimulus(8'h0F, 1'b1, 1'b0, k2);
        repeat (2) @(negedge clk);
        checkOutput("b2b_start_gap", k2 - k, 10 * BPS);
        checkOutput("b2b_valid_count", valid_cnt - v0, 2);
        n = valid_data.size();
        if (n >= 2) begin
            checkOutput("b2b_first_data", valid_data[n-2], 8'hA3);
            checkOutput("b2b_second_data", valid_data[n-1], 8'h0F);
            checkOutput("b2b_pulse_spacing", valid_cyc[n-1] - valid_cyc[n-2], 10 * BPS);
        end
        checkOutput("b2b_rx_data", rx_data, 8'h0F);
        repeat (BPS) @(posedge clk);

        $display("[TB] start-bit glitch then 3C");
        v0 = valid_cnt;
        e0 = err_cnt;
        busy_seen = 1'b0;
        @(posedge clk);
        #1 rx = 1'b0;
        repeat (HALF / 2) @(posedge clk);
        #1 rx = 1'b1;
        repeat (2 * BPS) @(negedge clk);
        checkOutput("glitch_entered_start", busy_seen, 1);
        checkOutput("glitch_back_idle", rx_busy, 0);
        checkOutput("glitch_no_pulses", (valid_cnt - v0) + (err_cnt - e0), 0);
        checkOutput("glitch_rx_data_held", rx_data, 8'h0F);
        applyStimulus(8'h3C, 1'b1, 1'b0, k);
        repeat (2) @(negedge clk);
        checkOutput("after_glitch_valid_count", valid_cnt - v0, 1);
        checkOutput("after_glitch_rx_data", rx_data, 8'h3C);
        repeat (BPS) @(posedge clk);

        $display("[TB] reset during bit 4 of FF, then 81");
        v0 = valid_cnt;
        e0 = err_cnt;
        @(posedge clk);
        #1 rx = 1'b0;
        repeat (BPS) @(posedge clk);
        #1 rx = 1'b1;
        repeat (4 * BPS + HALF) @(posedge clk);
        checkOutput("mid_frame_busy", rx_busy, 1);
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("midreset_rx_data", rx_data, 8'h00);
        checkOutput("midreset_rx_valid", rx_valid, 0);
        checkOutput("midreset_frame_err", frame_err, 0);
        checkOutput("midreset_rx_busy", rx_busy, 0);
        rst_n = 1'b1;
        repeat (6 * BPS) @(negedge clk);
        checkOutput("midreset_no_pulses", (valid_cnt - v0) + (err_cnt - e0), 0);
        applyStimulus(8'h81, 1'b1, 1'b0, k);
        repeat (2) @(negedge clk);
        checkOutput("after_reset_valid_count", valid_cnt - v0, 1);
        checkOutput("after_reset_rx_data", rx_data, 8'h81);
        repeat (BPS) @(posedge clk);

`ifdef UART_RX_MAJORITY_EN
        maj_exp = 8'h00;
`else
        maj_exp = 8'hFF;
`endif
        $display("[TB] frame 00 with a glitch at every data sample point");
        v0 = valid_cnt;
        applyStimulus(8'h00, 1'b1, 1'b1, k);
        repeat (2) @(negedge clk);
        checkOutput("sample_glitch_valid_count", valid_cnt - v0, 1);
        checkOutput("sample_glitch_rx_data", rx_data, maj_exp);
        if (valid_cyc.size() > 0) checkOutput("sample_glitch_latency", valid_cyc[$] - k, LAT);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
